m_load_unit: RTL
================

# m_load_unit

Load-path counterpart of the M-stage store byte-enable generator: issues word-aligned reads to the synchronous data memory, realigns the returned word, and sign- or zero-extends it for lw/lh/lhu/lb/lbu. Sits between the M-stage pipeline register and the W-stage writeback mux. Holds its result stable across W-stage stalls, even after the memory output has moved on. Flags misaligned loads (AdEL).

## Interface
Parameters:
- none; all widths fixed at 32-bit data/address, 5-bit register index.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid  in  1  M stage presents a load this cycle
- addr  in  32  byte address of load
- ld_sel  in  3  load type: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu; 6/7 treated as none
- rd_in  in  5  destination register index
- stall  in  1  W stage cannot consume this cycle
- flush  in  1  discard in-flight and incoming load
- mem_addr  out  32  {addr[31:2],2'b00}, combinational, always driven
- mem_rd  out  1  read strobe to data memory
- mem_rdata  in  32  memory read data, valid exactly one cycle after mem_rd
- ld_valid  out  1  ld_data/ld_rd valid for writeback
- ld_data  out  32  extended load result; 0 when ld_valid=0
- ld_rd  out  5  destination index of the result; 0 when ld_valid=0
- ld_adel  out  1  one-cycle misaligned-load flag

## Operation
- kind_ok = ld_sel in 1..5; aligned: lw needs addr[1:0]=0, lh/lhu need addr[0]=0, lb/lbu always aligned.
- go = req_valid & kind_ok & !stall & !flush & !reset.
- mem_rd = go & aligned (combinational).
- On go & aligned: register off=addr[1:0], ld_sel, rd_in; next state LIVE.
- On go & !aligned: no mem_rd; ld_adel=1 next cycle (registered), ld_valid stays 0.
- States: EMPTY, LIVE (result taken from mem_rdata this cycle), HELD (result taken from hold register).
- Transitions, priority order: reset → EMPTY; flush → EMPTY; stall & LIVE → capture mem_rdata into hold, HELD; stall & HELD → HELD; stall & EMPTY → EMPTY; !stall → LIVE if go&aligned, else EMPTY.
- ld_valid = (state != EMPTY).
- Source word w = (state==HELD) ? hold : mem_rdata.
- Extraction: lw → w; lh → sign-extend w[16*off[1]+15 -:16]; lhu → zero-extend the same halfword; lb → sign-extend w[8*off+7 -:8]; lbu → zero-extend the same byte.
- ld_adel clears the next cycle unless another misaligned go occurs. Flush or reset clears it.
- req_valid while stall=1 is ignored; upstream holds the request.

## Timing
- Reset: state EMPTY, hold=0, off/sel/rd regs=0. ld_valid=0, ld_data=0, ld_rd=0, ld_adel=0, mem_rd=0.
- Latency: request in cycle N (mem_rd=1) → ld_valid=1 with data in N+1, provided stall was low in N. Throughput one load per cycle back-to-back.
- Stall in N+1: output unchanged through all stalled cycles, regardless of mem_rdata changes. Result is consumed in the first cycle with stall=0.
- Flush and stall together: flush wins; next cycle EMPTY.
- Reset mid-LIVE/HELD: next cycle all outputs at reset values. mem_rd=0 during the reset cycle.
- A new request accepted in the same cycle a result is consumed: no bubble.

## Test plan
- Memory word at 0x10 = 0x80817F02. Loads at 0x10 and 0x12 give one cycle later:
  - lw 0x10 → 0x80817F02
  - lhu 0x10 → 0x00007F02
  - lh 0x12 → 0xFFFF8081
  - lb 0x12 → 0xFFFFFF81
  - lbu 0x12 → 0x00000081
  - lb 0x11 → 0x0000007F
- Back-to-back lw 0x10, lb 0x13, lbu 0x13, each with rd_in 8/9/10:
  - ld_valid high three consecutive cycles.
  - Data 0x80817F02, 0xFFFFFF80, 0x00000080; ld_rd 8/9/10.
- lw at 0x12 → mem_rd=0; next cycle ld_adel=1, ld_valid=0; the following cycle ld_adel=0.
- lh 0x12 accepted, then stall=1 for 3 cycles while the bench drives mem_rdata=0xDEADBEEF:
  - ld_data stays 0xFFFF8081, ld_valid=1 throughout.
  - mem_rd=0 despite req_valid=1.
- flush while HELD → next cycle ld_valid=0, ld_data=0. Flush and stall together with req_valid=1 → mem_rd=0.
- reset asserted while LIVE with a concurrent request → mem_rd=0; next cycle all outputs 0. A request after deassertion completes normally.

Source files
------------

// File: rtl/m_load_unit_if.sv
// Bundles the M-stage load request, data-memory read port and W-stage result
// bus for the load unit. The load unit takes the slave side.
interface m_load_unit_if;
  logic        req_valid;
  logic [31:0] addr;
  logic [2:0]  ld_sel;
  logic [4:0]  rd_in;
  logic        stall;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;
  logic        ld_adel;

  modport master (
    output req_valid, addr, ld_sel, rd_in, stall, flush, mem_rdata,
    input  mem_addr, mem_rd, ld_valid, ld_data, ld_rd, ld_adel
  );

  modport slave (
    input  req_valid, addr, ld_sel, rd_in, stall, flush, mem_rdata,
    output mem_addr, mem_rd, ld_valid, ld_data, ld_rd, ld_adel
  );
endinterface

// File: rtl/m_load_unit.sv
// Load unit: issues word-aligned reads to synchronous data memory, realigns and
// extends the returned word, holds it across W-stage stalls, flags AdEL.
module m_load_unit (
  input logic          clk,
  input logic          reset,
  m_load_unit_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, LIVE, HELD} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q;
  logic [1:0]  off_q;
  logic [2:0]  sel_q;
  logic [4:0]  rd_q;
  logic        adel_q;

  logic        kind_ok, aligned, go, accept;
  logic [31:0] w, res;
  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    kind_ok = bus.ld_sel inside {[3'd1:3'd5]};
    case (bus.ld_sel)
      3'd1:       aligned = (bus.addr[1:0] == 2'b00);
      3'd2, 3'd3: aligned = !bus.addr[0];
      default:    aligned = 1'b1;
    endcase
    go     = bus.req_valid & kind_ok & !bus.stall & !bus.flush & !reset;
    accept = go & aligned;
  end

  assign bus.mem_addr = {bus.addr[31:2], 2'b00};
  assign bus.mem_rd   = accept;

  always_comb begin
    state_d = state_q;
    if (reset || bus.flush) begin
      state_d = EMPTY;
    end else if (bus.stall) begin
      if (state_q == LIVE) state_d = HELD;
    end else begin
      state_d = accept ? LIVE : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      off_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adel_q  <= go & !aligned;
      if (accept) begin
        off_q <= bus.addr[1:0];
        sel_q <= bus.ld_sel;
        rd_q  <= bus.rd_in;
      end
      // Memory output is only valid for one cycle; snapshot it on the first stalled cycle.
      if (!bus.flush && bus.stall && state_q == LIVE) hold_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    w    = (state_q == HELD) ? hold_q : bus.mem_rdata;
    half = off_q[1] ? w[31:16] : w[15:0];
    case (off_q)
      2'd0:    byte_v = w[7:0];
      2'd1:    byte_v = w[15:8];
      2'd2:    byte_v = w[23:16];
      default: byte_v = w[31:24];
    endcase
    res = '0;
    case (sel_q)
      3'd1:    res = w;
      3'd2:    res = {{16{half[15]}}, half};
      3'd3:    res = {16'h0000, half};
      3'd4:    res = {{24{byte_v[7]}}, byte_v};
      3'd5:    res = {24'h000000, byte_v};
      default: res = '0;
    endcase
  end

  assign bus.ld_valid = (state_q != EMPTY);
  assign bus.ld_data  = bus.ld_valid ? res : '0;
  assign bus.ld_rd    = bus.ld_valid ? rd_q : '0;
  assign bus.ld_adel  = adel_q;
endmodule
